// File: rtl/regmap_arbiter.sv
// ---------------------------------------------------------------------------
// regmap_arbiter
//   Two-requester arbiter in front of a single-port 8-bit configuration
//   register file. Requester 0 is the UART command path. Requester 1 is the
//   on-chip calibration sequencer. One access is in flight at a time:
//     IDLE  -> grant a winner, pulse its ready, latch we/addr/wdata
//     ISSUE -> strobe the register file (or flag an address error)
//     WAIT  -> capture rf_rdata (reads only)
//     RESP  -> pulse the winner's rvalid with rdata/err
//
// Configuration macro:
//   REGMAP_ARB_FIXED_PRIO_EN  defined   : requester 0 always wins a tie and
//                                         no round-robin pointer is built.
//                             undefined : round-robin arbitration. The pointer
//                                         favours requester 0 after reset.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata request from requester N (held until ready)
//   reqN_ready              one-cycle accept pulse
//   reqN_rvalid/rdata/err   one-cycle completion with read data / addr error
//   rf_en/we/addr/wdata     register-file strobe and fields (0 when idle)
//   rf_rdata                register-file read data, one cycle after strobe
//   busy                    high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module regmap_arbiter #(
  parameter int NUMREGS = 42,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [7:0]        req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [7:0]        req1_rdata,
  output logic              req1_err,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [7:0]        rf_wdata,
  input  logic [7:0]        rf_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(NUMREGS);

  state_t            r_state;
  state_t            w_state_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_gnt;     // 0 = requester 0 owns the transaction
  logic              r_err;
  logic [7:0]        r_rdata;

  logic              w_any;
  logic              w_win;     // requester that would be granted now
  logic              w_accept;
  logic              w_addr_ok;

`ifndef REGMAP_ARB_FIXED_PRIO_EN
  logic              r_last;    // requester granted most recently
`endif

  assign w_addr_ok = (32'(r_addr) < ADDR_LIMIT);

  // Winner selection. With a single requester valid it simply wins; on a
  // tie either requester 0 always wins or the one not granted last wins.
  always_comb begin
    w_any = req0_valid | req1_valid;
`ifdef REGMAP_ARB_FIXED_PRIO_EN
    w_win = ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      w_win = ~r_last;
    end else begin
      w_win = ~req0_valid;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and all outputs
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    req0_rvalid  = 1'b0;
    req1_rvalid  = 1'b0;
    req0_rdata   = 8'd0;
    req1_rdata   = 8'd0;
    req0_err     = 1'b0;
    req1_err     = 1'b0;
    rf_en        = 1'b0;
    rf_we        = 1'b0;
    rf_addr      = '0;
    rf_wdata     = 8'd0;
    busy         = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        // No accept during a reset cycle: the latch would be cleared anyway,
        // so a ready pulse here would silently drop the request.
        if (w_any && !reset) begin
          w_accept     = 1'b1;
          req0_ready   = ~w_win;
          req1_ready   = w_win;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_addr_ok) begin
          rf_en        = 1'b1;
          rf_we        = r_we;
          rf_addr      = r_addr;
          rf_wdata     = r_wdata;
          w_state_next = r_we ? S_RESP : S_WAIT;
        end else begin
          w_state_next = S_RESP;
        end
      end
      S_WAIT: begin
        w_state_next = S_RESP;
      end
      S_RESP: begin
        if (r_gnt) begin
          req1_rvalid = 1'b1;
          req1_rdata  = r_rdata;
          req1_err    = r_err;
        end else begin
          req0_rvalid = 1'b1;
          req0_rdata  = r_rdata;
          req0_err    = r_err;
        end
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Request latch, error flag, read-data capture and arbitration pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 8'd0;
      r_gnt   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 8'd0;
`ifndef REGMAP_ARB_FIXED_PRIO_EN
      r_last  <= 1'b1;
`endif
    end else begin
      if (w_accept) begin
        r_gnt   <= w_win;
        r_we    <= w_win ? req1_we    : req0_we;
        r_addr  <= w_win ? req1_addr  : req0_addr;
        r_wdata <= w_win ? req1_wdata : req0_wdata;
        // rdata stays 0 unless a valid read later loads it in WAIT
        r_err   <= 1'b0;
        r_rdata <= 8'd0;
`ifndef REGMAP_ARB_FIXED_PRIO_EN
        r_last  <= w_win;
`endif
      end
      if (r_state == S_ISSUE && !w_addr_ok) begin
        r_err <= 1'b1;
      end
      if (r_state == S_WAIT) begin
        r_rdata <= rf_rdata;
      end
    end
  end

endmodule

// File: tb/tb_regmap_arbiter.sv
module tb_regmap_arbiter;

  localparam int NR = 42;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_we, req0_ready, req0_rvalid, req0_err;
  logic [AW-1:0] req0_addr;
  logic [7:0]    req0_wdata, req0_rdata;
  logic          req1_valid, req1_we, req1_ready, req1_rvalid, req1_err;
  logic [AW-1:0] req1_addr;
  logic [7:0]    req1_wdata, req1_rdata;
  logic          rf_en, rf_we, busy;
  logic [AW-1:0] rf_addr;
  logic [7:0]    rf_wdata, rf_rdata;

  always #5 clk = ~clk;

  regmap_arbiter #(.NUMREGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] stub_mem [64];   // register file as seen by the DUT
  logic [7:0] model_mem[64];   // register file as predicted by the model

  // Reference model: one transaction timeline at a time
  bit   m_act  = 0;
  int   m_g    = 0;
  bit   m_who  = 0;
  txn_t m_t;
  bit   m_last = 1;            // requester granted last (1 => 0 favoured)

  bit            prev_rd = 0;
  logic [AW-1:0] prev_addr = '0;

  // Observation log from the DUT
  int   g_cyc, en_cyc, rv_cyc, en_cnt, rv_cnt;
  bit   g_who, rv_who;
  logic [AW-1:0] en_addr;
  logic [7:0]    en_wd, rv_data;
  logic          en_we, rv_err;
  int   gseq[$];
  logic s_busy, s_rf_en, s_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_log();
    g_cyc = -100; en_cyc = -100; rv_cyc = -100; en_cnt = 0; rv_cnt = 0;
    g_who = 0; rv_who = 0; en_addr = '0; en_wd = '0; rv_data = '0;
    en_we = 0; rv_err = 0;
    gseq.delete();
  endtask

  // One clock cycle: drive inputs, predict, compare, advance the model.
  task automatic step(input bit rst);
    bit e_rdy0, e_rdy1, e_en, e_we, e_rv0, e_rv1, e_err, e_busy, inr, free, who;
    logic [AW-1:0] e_addr;
    logic [7:0] e_wd, e_rd;
    int d, lastd;
    txn_t h;
    @(negedge clk);
    cyc++;
    reset = rst;
    if (q0.size() > 0) begin
      req0_valid = 1; req0_we = q0[0].we; req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
    end else begin
      req0_valid = 0; req0_we = 1'($urandom); req0_addr = AW'($urandom); req0_wdata = 8'($urandom);
    end
    if (q1.size() > 0) begin
      req1_valid = 1; req1_we = q1[0].we; req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
    end else begin
      req1_valid = 0; req1_we = 1'($urandom); req1_addr = AW'($urandom); req1_wdata = 8'($urandom);
    end
    rf_rdata = prev_rd ? stub_mem[prev_addr] : 8'($urandom);
    #1;

    e_rdy0 = 0; e_rdy1 = 0; e_en = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0; e_err = 0;
    e_busy = 0; e_addr = '0; e_wd = '0; e_rd = '0; free = 1; d = 0; lastd = 0; who = 0;
    if (m_act) begin
      d     = cyc - m_g;
      inr   = (int'(m_t.addr) < NR);
      lastd = (m_t.we || !inr) ? 2 : 3;
      if (d >= 1 && d <= lastd) e_busy = 1;
      if (d == 1 && inr) begin
        e_en = 1; e_we = m_t.we; e_addr = m_t.addr; e_wd = m_t.wdata;
      end
      if (d == lastd) begin
        if (m_who) e_rv1 = 1; else e_rv0 = 1;
        e_err = !inr;
        e_rd  = (!m_t.we && inr) ? model_mem[m_t.addr] : 8'd0;
      end
      free = (d > lastd);
    end
    if (free && !rst && (req0_valid || req1_valid)) begin
`ifdef REGMAP_ARB_FIXED_PRIO_EN
      who = !req0_valid;
`else
      who = (req0_valid && req1_valid) ? !m_last : !req0_valid;
`endif
      if (who) e_rdy1 = 1; else e_rdy0 = 1;
    end

    chk("ready0", req0_ready, e_rdy0);
    chk("ready1", req1_ready, e_rdy1);
    chk("rf_en", rf_en, e_en);
    chk("rf_we", rf_we, e_we);
    chk("rf_addr", rf_addr, e_addr);
    chk("rf_wdata", rf_wdata, e_wd);
    chk("rvalid0", req0_rvalid, e_rv0);
    chk("rvalid1", req1_rvalid, e_rv1);
    chk("busy", busy, e_busy);
    if (e_rv0) begin chk("rdata0", req0_rdata, e_rd); chk("err0", req0_err, e_err); end
    if (e_rv1) begin chk("rdata1", req1_rdata, e_rd); chk("err1", req1_err, e_err); end

    s_busy = busy; s_rf_en = rf_en; s_rv = req0_rvalid | req1_rvalid;
    if (req0_ready) begin g_cyc = cyc; g_who = 0; gseq.push_back(0); end
    if (req1_ready) begin g_cyc = cyc; g_who = 1; gseq.push_back(1); end
    if (rf_en) begin
      en_cyc = cyc; en_cnt++; en_addr = rf_addr; en_wd = rf_wdata; en_we = rf_we;
    end
    if (req0_rvalid) begin rv_cyc = cyc; rv_cnt++; rv_who = 0; rv_data = req0_rdata; rv_err = req0_err; end
    if (req1_rvalid) begin rv_cyc = cyc; rv_cnt++; rv_who = 1; rv_data = req1_rdata; rv_err = req1_err; end
    $display("cyc=%0d rst=%0b v=%0b%0b rdy=%0b%0b en=%0b we=%0b a=%0d wd=%02h rv=%0b%0b busy=%0b",
             cyc, rst, req0_valid, req1_valid, req0_ready, req1_ready, rf_en, rf_we,
             rf_addr, rf_wdata, req0_rvalid, req1_rvalid, busy);

    // Register-file stub follows the DUT's strobes
    if (rf_en && rf_we) stub_mem[rf_addr] = rf_wdata;
    prev_rd   = rf_en && !rf_we;
    prev_addr = rf_addr;

    if (free) m_act = 0;
    if (rst) begin
      m_act  = 0;
      m_last = 1;
    end else if (e_rdy0 || e_rdy1) begin
      if (who) h = q1.pop_front(); else h = q0.pop_front();
      m_act = 1; m_g = cyc; m_who = who; m_t = h; m_last = who;
      if (h.we && int'(h.addr) < NR) model_mem[h.addr] = h.wdata;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  initial begin
    logic [7:0] v;
    txn_t t;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      stub_mem[i] = v;
      model_mem[i] = v;
    end
    reset = 1; req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0; rf_rdata = '0;
    repeat (2) @(negedge clk);
    step(1);
    step(0);
    chk("reset_busy", s_busy, 0);
    chk("reset_rf_en", s_rf_en, 0);
    chk("reset_rvalid", s_rv, 0);

    // Single write
    clear_log();
    q0.push_back('{we: 1'b1, addr: 6'd5, wdata: 8'hA5});
    drain(5);
    chk("wr_grant_who", g_who, 0);
    chk("wr_en_lat", en_cyc - g_cyc, 1);
    chk("wr_en_we", en_we, 1);
    chk("wr_en_addr", en_addr, 5);
    chk("wr_en_data", en_wd, 8'hA5);
    chk("wr_rv_lat", rv_cyc - g_cyc, 2);
    chk("wr_rv_who", rv_who, 0);
    chk("wr_rv_err", rv_err, 0);
    chk("wr_stub", stub_mem[5], 8'hA5);

    // Single read
    clear_log();
    stub_mem[12] = 8'h3C; model_mem[12] = 8'h3C;
    q1.push_back('{we: 1'b0, addr: 6'd12, wdata: 8'h00});
    drain(6);
    chk("rd_grant_who", g_who, 1);
    chk("rd_rv_lat", rv_cyc - g_cyc, 3);
    chk("rd_rv_who", rv_who, 1);
    chk("rd_rv_data", rv_data, 8'h3C);
    chk("rd_rv_err", rv_err, 0);

    // Out-of-range write
    clear_log();
    q0.push_back('{we: 1'b1, addr: 6'd42, wdata: 8'h77});
    drain(5);
    chk("oor_en_cnt", en_cnt, 0);
    chk("oor_rv_lat", rv_cyc - g_cyc, 2);
    chk("oor_rv_err", rv_err, 1);
    chk("oor_rv_data", rv_data, 0);

    // Contention from a fresh reset
    step(1);
    clear_log();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{we: 1'($urandom), addr: AW'($urandom_range(0, NR-1)), wdata: 8'($urandom)});
      q1.push_back('{we: 1'($urandom), addr: AW'($urandom_range(0, NR-1)), wdata: 8'($urandom)});
    end
    drain(40);
    chk("cont_cnt", gseq.size(), 8);
    for (int i = 0; i < 4; i++) begin
`ifdef REGMAP_ARB_FIXED_PRIO_EN
      chk("cont_order", (gseq.size() > i) ? gseq[i] : 9, 0);
`else
      chk("cont_order", (gseq.size() > i) ? gseq[i] : 9, i % 2);
`endif
    end

    // Reset in WAIT aborts the read
    clear_log();
    q1.push_back('{we: 1'b0, addr: 6'd3, wdata: 8'h00});
    step(0);
    chk("rst_grant", g_who, 1);
    step(0);
    step(1);
    step(0);
    chk("rst_busy_after", s_busy, 0);
    chk("rst_en_after", s_rf_en, 0);
    chk("rst_rv_after", s_rv, 0);
    drain(4);
    chk("rst_no_rvalid", rv_cnt, 0);
    clear_log();
    stub_mem[7] = 8'h5A; model_mem[7] = 8'h5A;
    q1.push_back('{we: 1'b0, addr: 6'd7, wdata: 8'h00});
    drain(6);
    chk("post_rst_who", rv_who, 1);
    chk("post_rst_lat", rv_cyc - g_cyc, 3);
    chk("post_rst_data", rv_data, 8'h5A);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if (q0.size() < 4 && $urandom_range(0, 3) == 0) begin
        t.we = 1'($urandom); t.addr = AW'($urandom_range(0, 47)); t.wdata = 8'($urandom);
        q0.push_back(t);
      end
      if (q1.size() < 4 && $urandom_range(0, 3) == 0) begin
        t.we = 1'($urandom); t.addr = AW'($urandom_range(0, 47)); t.wdata = 8'($urandom);
        q1.push_back(t);
      end
      step(0);
    end
    drain(40);
    chk("drain_empty", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
